irq_timer: RTL and testbench

- Memory-mapped countdown timer and interrupt source: the device side of the CPU's external-interrupt interface.
- `irq` feeds one bit of CP0 HWIn; CP0 masks it (SR.IM) and raises Req on the processor side.
- Software programs the block with sw/lw through the data-memory bridge: load PRESET, set CTRL, take the interrupt, re-arm via CTRL write.

---
 rtl/irq_timer.sv | 99 +++++++++
 tb/tb_irq_timer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer.sv
// Memory-mapped countdown timer that raises an interrupt request for CP0 HWIn.
// Software loads PRESET, enables through CTRL, and re-arms or acknowledges with a CTRL write.
module irq_timer #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t             state;
    logic [3:0]         ctrl;
    logic [CNT_W-1:0]   preset;
    logic [CNT_W-1:0]   count;
    logic               irq_flag;

    logic               en;
    logic               auto_reload;

    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);

    // Bus writes come last so they override any same-cycle FSM update of CTRL or irq_flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (count == '0) begin
                        state    <= S_INT;
                        irq_flag <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                S_INT: begin
                    if (auto_reload) begin
                        irq_flag <= 1'b0;
                        state    <= S_LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (we && addr == 2'd0) begin
                ctrl     <= wdata[3:0];
                irq_flag <= 1'b0;
            end
            if (we && addr == 2'd1) begin
                preset <= wdata[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = 32'(preset);
            2'd2:    rdata = 32'(count);
            default: rdata = '0;
        endcase
    end

    assign irq = irq_flag & ctrl[3];

endmodule

// File: tb/tb_irq_timer.sv
// Self-checking bench for irq_timer: fixed vector table, corner-case sequences,
// and randomized bus traffic compared against a run-timeline reference model.
module tb_irq_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp;
    int n_fail;

    irq_timer #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: a run is a timeline of edges. Edge 1 loads PRESET into p,
    // edges 2..p+1 count down, edge p+2 raises the flag, edge p+3 ends or reloads.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_flag;
    bit          m_run;
    longint      m_n;
    longint      m_p;

    task automatic model_step(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        if (r) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
            m_flag = 1'b0; m_run = 1'b0; m_n = 0; m_p = 0;
            return;
        end
        if (!m_run) begin
            if (m_ctrl[0]) begin
                m_run = 1'b1;
                m_n   = 1;
            end
        end else if (m_n == 1) begin
            m_count = m_preset;
            m_p     = longint'(m_preset);
            m_n     = 2;
        end else if (m_n <= m_p + 2) begin
            if (!m_ctrl[0]) begin
                m_run = 1'b0;
            end else begin
                if (m_n == m_p + 2) m_flag = 1'b1;
                else m_count = 32'(m_p - (m_n - 1));
                m_n++;
            end
        end else begin
            if (m_ctrl[2:1] == 2'b01) begin
                m_flag = 1'b0;
                m_n    = 1;
            end else begin
                m_ctrl[0] = 1'b0;
                m_run     = 1'b0;
            end
        end
        if (w && a == 2'd0) begin
            m_ctrl = d[3:0];
            m_flag = 1'b0;
        end
        if (w && a == 2'd1) m_preset = d;
    endtask

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0:       return {28'd0, m_ctrl};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bus cycle, advance the model, then sweep every address against it.
    task automatic applyStimulus(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = r; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_step(r, w, a, d);
        #1;
        we = 1'b0; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            #1;
            checkOutput($sformatf("model_rdata[%0d]", i), rdata, model_read(i));
        end
        addr = a;
        #1;
        checkOutput("model_irq", {31'd0, irq}, {31'd0, (m_flag & m_ctrl[3])});
    endtask

    task automatic idle_ticks(input int k);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 2'd2, 32'd0);
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_irq;
    } vec_t;

    vec_t vecs[21];

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;

        // Reset state, one-shot run with PRESET=5, acknowledge, and register edge cases.
        vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0, 1'b0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0, 1'b0};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 32'd5,         32'd5, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 32'h9,         32'h9, 1'b0};
        vecs[6]  = '{1'b0, 2'd2, 32'h0,         32'd0, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,         32'd5, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 32'h0,         32'd4, 1'b0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,         32'd3, 1'b0};
        vecs[10] = '{1'b0, 2'd2, 32'h0,         32'd2, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 32'h0,         32'd1, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 32'h0,         32'd0, 1'b0};
        vecs[13] = '{1'b0, 2'd2, 32'h0,         32'd0, 1'b1};
        vecs[14] = '{1'b0, 2'd0, 32'h0,         32'h8, 1'b1};
        vecs[15] = '{1'b0, 2'd0, 32'h0,         32'h8, 1'b1};
        vecs[16] = '{1'b1, 2'd0, 32'h8,         32'h8, 1'b0};
        vecs[17] = '{1'b1, 2'd3, 32'hFFFF,      32'h0, 1'b0};
        vecs[18] = '{1'b1, 2'd2, 32'd77,        32'h0, 1'b0};
        vecs[19] = '{1'b1, 2'd0, 32'hFFFF_FFF6, 32'h6, 1'b0};
        vecs[20] = '{1'b0, 2'd1, 32'h0,         32'd5, 1'b0};

        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 21; i++) begin
            applyStimulus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // Auto-reload, PRESET=3: single-cycle pulse every 6 cycles.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd3);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'hB);
        for (int k = 1; k <= 26; k++) begin
            idle_ticks(1);
            checkOutput($sformatf("auto_irq_E%0d", k), {31'd0, irq}, {31'd0, (k % 6 == 0)});
        end

        // IM=0: flag set silently, EN self-clears, CTRL write clears the flag.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd10);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h1);
        for (int k = 1; k <= 20; k++) begin
            idle_ticks(1);
            checkOutput("im0_irq", {31'd0, irq}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
        checkOutput("im0_ctrl_en_cleared", rdata, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h8);
        checkOutput("im0_ack_irq", {31'd0, irq}, 32'd0);

        // Mid-count disable freezes COUNT; re-enable reloads; PRESET rewrite waits for next LOAD.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd20);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
        idle_ticks(9);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h8);
        idle_ticks(3);
        checkOutput("mid_frozen_count", rdata, 32'd12);
        checkOutput("mid_frozen_irq", {31'd0, irq}, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
        idle_ticks(2);
        checkOutput("mid_reload_count", rdata, 32'd20);
        idle_ticks(1);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd2);
        idle_ticks(18);
        checkOutput("mid_preset_rewrite_no_early_irq", {31'd0, irq}, 32'd0);
        checkOutput("mid_count_reaches_zero", rdata, 32'd0);
        idle_ticks(1);
        checkOutput("mid_irq_at_F23", {31'd0, irq}, 32'd1);

        // PRESET=0: irq at E0+3, then reset while in INT.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
        idle_ticks(2);
        checkOutput("p0_irq_E2", {31'd0, irq}, 32'd0);
        idle_ticks(1);
        checkOutput("p0_irq_E3", {31'd0, irq}, 32'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("reset_in_int_irq", {31'd0, irq}, 32'd0);
        checkOutput("reset_in_int_ctrl", rdata, 32'd0);

        // CTRL write on the same edge the flag would rise: write wins, still enters INT.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd2);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
        idle_ticks(4);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
        checkOutput("race_set_irq", {31'd0, irq}, 32'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
        checkOutput("race_set_ctrl_after_int", rdata, 32'h8);

        // CTRL write on the INT edge: bus wins for CTRL, FSM goes IDLE, then relaunches.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd2);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
        idle_ticks(5);
        checkOutput("race_int_irq_before", {31'd0, irq}, 32'd1);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
        checkOutput("race_int_ctrl", rdata, 32'h9);
        checkOutput("race_int_irq", {31'd0, irq}, 32'd0);
        idle_ticks(2);
        checkOutput("race_int_relaunch_count", rdata, 32'd2);

        // Randomized traffic against the reference model.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        for (int k = 0; k < 600; k++) begin
            bit          r;
            bit          w;
            logic [1:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 149) == 0);
            w = ($urandom_range(0, 2) == 0);
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd1) ? 32'($urandom_range(0, 12)) : $urandom;
            applyStimulus(r, w, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
